// File: rtl/trisc_uart_tx.sv
// TRISC CPU-port UART transmitter: write FIFO, 8N1 framer, sticky overflow status.
// Define TRISC_UART_PARITY_EN to insert an even-parity bit (8E1 framing).
module trisc_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       io_wr,
   input  logic [7:0] io_wr_data,
   input  logic       io_rd,
   output logic [7:0] io_rd_data,
   output logic       txd
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [15:0] TLOAD = 16'(CLKS_PER_BIT - 1);

`ifdef TRISC_UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_e;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          ovf_q, ovf_d;
   state_e        state_q;
   logic [15:0]   timer_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q;
   logic          txd_q;
`ifdef TRISC_UART_PARITY_EN
   logic          par_q;
`endif

   logic       empty, full, bit_end, pop, push, drop, busy;
   logic [7:0] head;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign bit_end = (timer_q == '0);
   // A pop frees the slot on the same edge, so a write to a full FIFO is still taken.
   assign pop     = !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
   assign push    = io_wr && (!full || pop);
   assign drop    = io_wr && full && !pop;
   assign busy    = (state_q != IDLE) || !empty;

   assign io_rd_data = {5'b0, ovf_q, full, busy};
   assign txd        = txd_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (drop)       ovf_d = 1'b1;
      else if (io_rd) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= io_wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ovf_q     <= 1'b0;
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         txd_q     <= 1'b1;
`ifdef TRISC_UART_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
         unique case (state_q)
            IDLE: begin
               txd_q <= 1'b1;
               if (pop) begin
                  shift_q <= head;
`ifdef TRISC_UART_PARITY_EN
                  par_q   <= ^head;
`endif
                  timer_q <= TLOAD;
                  txd_q   <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (bit_end) begin
                  timer_q   <= TLOAD;
                  bit_cnt_q <= '0;
                  txd_q     <= shift_q[0];
                  state_q   <= DATA;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  timer_q <= TLOAD;
                  if (bit_cnt_q == 3'd7) begin
`ifdef TRISC_UART_PARITY_EN
                     txd_q   <= par_q;
                     state_q <= PAR;
`else
                     txd_q   <= 1'b1;
                     state_q <= STOP;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                     shift_q   <= {1'b0, shift_q[7:1]};
                     txd_q     <= shift_q[1];
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
`ifdef TRISC_UART_PARITY_EN
            PAR: begin
               if (bit_end) begin
                  timer_q <= TLOAD;
                  txd_q   <= 1'b1;
                  state_q <= STOP;
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
`endif
            STOP: begin
               if (bit_end) begin
                  // Back-to-back frames: the next start bit follows the stop bit directly.
                  if (pop) begin
                     shift_q <= head;
`ifdef TRISC_UART_PARITY_EN
                     par_q   <= ^head;
`endif
                     timer_q <= TLOAD;
                     txd_q   <= 1'b0;
                     state_q <= START;
                  end else begin
                     txd_q   <= 1'b1;
                     state_q <= IDLE;
                  end
               end else begin
                  timer_q <= timer_q - 16'd1;
               end
            end
            default: begin
               txd_q   <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_trisc_uart_tx.sv
// Bench for trisc_uart_tx: frame-level reference model checked every cycle, plus directed cases.
module tb_trisc_uart_tx;

   localparam int unsigned CPB   = 4;
   localparam int unsigned DEPTH = 4;
`ifdef TRISC_UART_PARITY_EN
   localparam int unsigned FL = 11;
`else
   localparam int unsigned FL = 10;
`endif
   localparam int unsigned LAST = FL * CPB - 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       io_wr = 1'b0;
   logic [7:0] io_wr_data = '0;
   logic       io_rd = 1'b0;
   logic [7:0] io_rd_data;
   logic       txd;

   int checks = 0;
   int errors = 0;

   trisc_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .io_wr(io_wr), .io_wr_data(io_wr_data),
      .io_rd(io_rd), .io_rd_data(io_rd_data), .txd(txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Serial frame bit i: start, 8 data LSB first, optional even parity, stop.
   function automatic logic frame_bit(input logic [7:0] d, input int unsigned i);
      if (i == 0) return 1'b0;
      if (i <= 8) return d[i-1];
`ifdef TRISC_UART_PARITY_EN
      if (i == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Reference model: queue of pending bytes plus the frame in flight and its cycle index.
   logic [7:0]  q[$];
   logic [7:0]  cur = '0;
   bit          active = 0;
   int unsigned t = 0;
   bit          ovf_m = 0;
   bit          pop_m, full_pre, drop_m;
   logic        exp_txd;
   logic [7:0]  exp_rd;

   always @(posedge clk) begin
      if (!reset) begin
         q.delete();
         active = 0;
         t      = 0;
         ovf_m  = 0;
      end else begin
         full_pre = (q.size() == DEPTH);
         pop_m    = (q.size() != 0) && (!active || t == LAST);
         drop_m   = io_wr && full_pre && !pop_m;
         if (pop_m) begin
            cur    = q.pop_front();
            active = 1;
            t      = 0;
         end else if (active) begin
            if (t == LAST) active = 0;
            else           t++;
         end
         if (io_wr && !drop_m) q.push_back(io_wr_data);
         if (drop_m)     ovf_m = 1;
         else if (io_rd) ovf_m = 0;
      end
      #1;
      exp_txd = active ? frame_bit(cur, t / CPB) : 1'b1;
      exp_rd  = {5'b0, ovf_m, q.size() == DEPTH, active || (q.size() != 0)};
      check("model_txd", {7'b0, txd}, {7'b0, exp_txd});
      check("model_status", io_rd_data, exp_rd);
   end

   task automatic wait_idle(input int limit, output int n);
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (io_rd_data[0] !== 1'b0 && n < limit);
      check("idle_timeout", {7'b0, io_rd_data[0]}, 8'h00);
   endtask

   logic [FL-1:0] exp_a5;
   int n;

   initial begin
`ifdef TRISC_UART_PARITY_EN
      exp_a5 = 11'b1_0_10100101_0;
`else
      exp_a5 = 10'b1_10100101_0;
`endif
      repeat (3) @(negedge clk);
      reset = 1'b1;

      // Quiet line after reset
      repeat (20) begin
         @(posedge clk); #2;
         check("idle_txd", {7'b0, txd}, 8'h01);
         check("idle_status", io_rd_data, 8'h00);
      end

      // Single byte 0xA5, bit-by-bit against a literal frame
      @(negedge clk); io_wr = 1'b1; io_wr_data = 8'hA5;
      @(negedge clk); io_wr = 1'b0;
      for (int unsigned c = 0; c < FL * CPB; c++) begin
         @(posedge clk); #2;
         check("a5_frame", {7'b0, txd}, {7'b0, exp_a5[c / CPB]});
      end
      @(posedge clk); #2;
      check("a5_not_busy", io_rd_data, 8'h00);
      repeat (5) @(negedge clk);

      // Five back-to-back writes: all fit, frames run without gaps
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); io_wr = 1'b1; io_wr_data = 8'(i);
      end
      @(negedge clk); io_wr = 1'b0;
      check("five_no_ovf", io_rd_data, 8'h03);
      wait_idle(3000, n);
      check("five_duration", 8'(n), 8'(5 * FL * CPB - 3));
      repeat (3) @(negedge clk);

      // Six writes: sixth dropped, ovf cleared by a status read
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); io_wr = 1'b1; io_wr_data = 8'(8'h10 + i);
      end
      @(negedge clk); io_wr = 1'b0;
      check("six_ovf", io_rd_data, 8'h07);
      io_rd = 1'b1;
      @(negedge clk); io_rd = 1'b0;
      check("six_rd_clear", io_rd_data, 8'h03);
      // Write while full, landing on the STOP-to-START pop edge
      repeat (FL * CPB - 6) @(negedge clk);
      io_wr = 1'b1; io_wr_data = 8'h5A;
      @(negedge clk); io_wr = 1'b0;
      check("wr_on_pop", io_rd_data, 8'h03);
      wait_idle(3000, n);
      repeat (3) @(negedge clk);

      // Reset in the middle of data bit 3 of a 0x00 byte
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); io_wr = 1'b1; io_wr_data = (i == 0) ? 8'h00 : 8'hFF;
      end
      @(negedge clk); io_wr = 1'b0;
      repeat (16) @(negedge clk);
      check("pre_reset_low", {7'b0, txd}, 8'h00);
      #1 reset = 1'b0;
      #1;
      check("async_reset_txd", {7'b0, txd}, 8'h01);
      check("async_reset_status", io_rd_data, 8'h00);
      @(negedge clk); reset = 1'b1;
      repeat (60) begin
         @(posedge clk); #2;
         check("post_reset_quiet", {7'b0, txd}, 8'h01);
      end

      // Randomized traffic with varying write density
      for (int blk = 0; blk < 12; blk++) begin
         int unsigned wmod;
         wmod = $urandom_range(1, 60);
         repeat (250) begin
            @(negedge clk);
            io_wr      = ($urandom % wmod) == 0;
            io_wr_data = 8'($urandom);
            io_rd      = ($urandom % 10) == 0;
         end
      end
      @(negedge clk); io_wr = 1'b0; io_rd = 1'b0;
      wait_idle(5000, n);
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
